// File: rtl/ram_responder_if.sv
// Memory-side bus between the memory controller and the RAM responder.
// The controller drives address, data and strobes; the responder answers with state and read data.
interface ram_responder_if;
   logic [31:0] memaddr;
   logic [31:0] memstore;
   logic        memREN;
   logic        memWEN;
   logic [31:0] ramload;
   logic [1:0]  ramstate;

   modport master (
      output memaddr, memstore, memREN, memWEN,
      input  ramload, ramstate
   );

   modport slave (
      input  memaddr, memstore, memREN, memWEN,
      output ramload, ramstate
   );
endinterface

// File: rtl/ram_responder.sv
// Word-addressed RAM responder with a programmable BUSY latency before each ACCESS.
// state  | meaning
// S_IDLE | no transaction in flight; a new request starts one
// S_WAIT | counting BUSY cycles for the latched request
// S_DONE | latched request gets its ACCESS cycle if still presented unchanged
module ram_responder #(
   parameter int LAT   = 2,
   parameter int DEPTH = 16384
) (
   input  logic          CLK,
   input  logic          nRST,
   ram_responder_if.slave bus
);
   localparam int AW = $clog2(DEPTH);

   localparam logic [1:0] RS_FREE   = 2'b00;
   localparam logic [1:0] RS_BUSY   = 2'b01;
   localparam logic [1:0] RS_ACCESS = 2'b10;
   localparam logic [1:0] RS_ERROR  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t        st;
   logic [3:0]    cnt;
   logic [31:0]   lat_addr;
   logic          lat_wen;

   logic [31:0]   mem [DEPTH];

   logic [AW-1:0] widx;
   logic          req;
   logic          both;
   logic          addr_ok;
   logic          err;
   logic          match;
   logic          access;
   logic          wr_en;
   logic [1:0]    ramstate_c;
   logic [31:0]   ramload_c;

   assign widx    = bus.memaddr[AW+1:2];
   assign req     = bus.memREN ^ bus.memWEN;
   assign both    = bus.memREN & bus.memWEN;
   assign addr_ok = (bus.memaddr[1:0] == 2'b00) && (bus.memaddr[31:AW+2] == '0);
   assign err     = both | (req & ~addr_ok);
   assign match   = req && (bus.memaddr == lat_addr) && (bus.memWEN == lat_wen);
   assign access  = ~err && (st == S_DONE) && match;

   // A reset edge in the ACCESS cycle must suppress the write.
   assign wr_en   = nRST & access & bus.memWEN;

   always_comb begin
      ramstate_c = RS_FREE;
      ramload_c  = '0;
      if (err) begin
         ramstate_c = RS_ERROR;
      end else if (access) begin
         ramstate_c = RS_ACCESS;
         if (!bus.memWEN) begin
            ramload_c = mem[widx];
         end
      end else if (req) begin
         ramstate_c = RS_BUSY;
      end
   end

   assign bus.ramstate = ramstate_c;
   assign bus.ramload  = ramload_c;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         st       <= S_IDLE;
         cnt      <= '0;
         lat_addr <= '0;
         lat_wen  <= 1'b0;
      end else if (err || !req) begin
         st <= S_IDLE;
      end else if (st == S_IDLE || !match) begin
         // Fresh arrival, or the controller changed its request mid-flight: restart.
         lat_addr <= bus.memaddr;
         lat_wen  <= bus.memWEN;
         cnt      <= 4'(LAT - 1);
         st       <= (LAT == 1) ? S_DONE : S_WAIT;
      end else if (st == S_WAIT) begin
         cnt <= cnt - 4'd1;
         if (cnt == 4'd1) begin
            st <= S_DONE;
         end
      end else begin
         st <= S_IDLE;
      end
   end

   always_ff @(posedge CLK) begin
      if (wr_en) begin
         mem[widx] <= bus.memstore;
      end
   end
endmodule
